// File: rtl/controlador_vga_param.sv
`default_nettype none
// controlador_vga_param: parametrised VGA timing generator with pixel strobe and NxN board-cell decode.
// Rev 1.0
module controlador_vga_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SW     = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SW     = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 10,
  parameter int GRID_N   = 3,
  parameter int CELDA    = 160,
  parameter int LINEA    = 4,
  parameter int ORIG_X   = 80,
  parameter int ORIG_Y   = 0
) (
  input  logic                                          clk,
  input  logic                                          botonRST,
  input  logic                                          en,
  output logic                                          pix_en,
  output logic                                          H_SYNC,
  output logic                                          V_SYNC,
  output logic                                          SYNC_BLANK,
  output logic                                          SYNC_B,
  output logic [CNT_W-1:0]                              cuentaX,
  output logic [CNT_W-1:0]                              cuentaY,
  output logic                                          inicioLinea,
  output logic                                          inicioCuadro,
  output logic [((GRID_N > 2) ? $clog2(GRID_N) : 1)-1:0] celdaCol,
  output logic [((GRID_N > 2) ? $clog2(GRID_N) : 1)-1:0] celdaFila,
  output logic                                          enCelda,
  output logic                                          enBorde
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SW + V_BP;
  localparam int CW      = (GRID_N > 2) ? $clog2(GRID_N) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OFF_W   = (CELDA > 1) ? $clog2(CELDA) : 1;

  if (H_TOTAL > (1 << CNT_W)) begin : g_err_h_total
    $error("H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_err_v_total
    $error("V_TOTAL does not fit in CNT_W bits");
  end
  if (CLK_DIV < 1) begin : g_err_clk_div
    $error("CLK_DIV must be at least 1");
  end
  if (ORIG_X + GRID_N * CELDA > H_ACTIVE) begin : g_err_grid_x
    $error("grid exceeds the visible width");
  end
  if (ORIG_Y + GRID_N * CELDA > V_ACTIVE) begin : g_err_grid_y
    $error("grid exceeds the visible height");
  end
  if (LINEA >= CELDA) begin : g_err_linea
    $error("LINEA must be smaller than CELDA");
  end

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W:0]   HS_ON     = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0]   HS_OFF    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SW);
  localparam logic [CNT_W:0]   VS_ON     = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0]   VS_OFF    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SW);
  localparam logic [CNT_W:0]   H_VIS     = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0]   V_VIS     = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W-1:0] GX0       = CNT_W'(ORIG_X);
  localparam logic [CNT_W-1:0] GY0       = CNT_W'(ORIG_Y);
  localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(CELDA - 1);
  localparam logic [OFF_W-1:0] LINEA_W   = OFF_W'(LINEA);
  localparam logic [OFF_W-1:0] TAIL      = OFF_W'(CELDA - LINEA);
  localparam logic [CW-1:0]    CELL_LAST = CW'(GRID_N - 1);
  localparam bit               HAS_LINE  = (LINEA > 0);
  localparam bit               GX_IN0    = (ORIG_X == 0);
  localparam bit               GY_IN0    = (ORIG_Y == 0);
  localparam bit               BORDE0    = GX_IN0 && GY_IN0 && HAS_LINE;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             line_wrap, frame_wrap;

  logic             gx_in_q, gx_in_d, gy_in_q, gy_in_d;
  logic [OFF_W-1:0] gx_off_q, gx_off_d, gy_off_q, gy_off_d;
  logic [CW-1:0]    gx_col_q, gx_col_d, gy_fila_q, gy_fila_d;

  logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic             ini_lin_q, ini_lin_d, ini_cua_q, ini_cua_d;
  logic             en_celda_q, en_celda_d, en_borde_q, en_borde_d;
  logic [CW-1:0]    col_q, col_d, fila_q, fila_d;

  // Gated by the reset pin so no strobe is seen while reset is held.
  assign pix_en = botonRST & en & (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;
    if (pix_en) begin
      if (x_q == X_LAST) begin
        x_d       = '0;
        line_wrap = 1'b1;
        if (y_q == Y_LAST) begin
          y_d        = '0;
          frame_wrap = 1'b1;
        end else begin
          y_d = y_q + CNT_W'(1);
        end
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  // Horizontal sub-cell tracker: enters at ORIG_X, steps offset/column, leaves after the last cell.
  always_comb begin
    gx_in_d  = gx_in_q;
    gx_off_d = gx_off_q;
    gx_col_d = gx_col_q;
    if (pix_en) begin
      if (line_wrap) begin
        gx_in_d  = GX_IN0;
        gx_off_d = '0;
        gx_col_d = '0;
      end else if (!gx_in_q) begin
        if (x_d == GX0) begin
          gx_in_d  = 1'b1;
          gx_off_d = '0;
          gx_col_d = '0;
        end
      end else if (gx_off_q == OFF_LAST) begin
        gx_off_d = '0;
        if (gx_col_q == CELL_LAST) begin
          gx_in_d  = 1'b0;
          gx_col_d = '0;
        end else begin
          gx_col_d = gx_col_q + CW'(1);
        end
      end else begin
        gx_off_d = gx_off_q + OFF_W'(1);
      end
    end
  end

  // Vertical tracker steps once per line wrap.
  always_comb begin
    gy_in_d   = gy_in_q;
    gy_off_d  = gy_off_q;
    gy_fila_d = gy_fila_q;
    if (line_wrap) begin
      if (frame_wrap) begin
        gy_in_d   = GY_IN0;
        gy_off_d  = '0;
        gy_fila_d = '0;
      end else if (!gy_in_q) begin
        if (y_d == GY0) begin
          gy_in_d   = 1'b1;
          gy_off_d  = '0;
          gy_fila_d = '0;
        end
      end else if (gy_off_q == OFF_LAST) begin
        gy_off_d = '0;
        if (gy_fila_q == CELL_LAST) begin
          gy_in_d   = 1'b0;
          gy_fila_d = '0;
        end else begin
          gy_fila_d = gy_fila_q + CW'(1);
        end
      end else begin
        gy_off_d = gy_off_q + OFF_W'(1);
      end
    end
  end

  // Outputs decode the next coordinate so they register alongside it.
  always_comb begin
    hs_d       = (({1'b0, x_d} >= HS_ON) && ({1'b0, x_d} < HS_OFF)) ? H_POL : ~H_POL;
    vs_d       = (({1'b0, y_d} >= VS_ON) && ({1'b0, y_d} < VS_OFF)) ? V_POL : ~V_POL;
    blank_d    = ({1'b0, x_d} < H_VIS) && ({1'b0, y_d} < V_VIS);
    ini_lin_d  = line_wrap;
    ini_cua_d  = frame_wrap;
    en_celda_d = gx_in_d & gy_in_d;
    col_d      = en_celda_d ? gx_col_d : '0;
    fila_d     = en_celda_d ? gy_fila_d : '0;
    en_borde_d = en_celda_d & HAS_LINE &
                 ((gx_off_d < LINEA_W) || (gy_off_d < LINEA_W) ||
                  ((gx_col_d == CELL_LAST) && (gx_off_d >= TAIL)) ||
                  ((gy_fila_d == CELL_LAST) && (gy_off_d >= TAIL)));
  end

  always_ff @(posedge clk or negedge botonRST) begin
    if (!botonRST) begin
      div_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      gx_in_q    <= GX_IN0;
      gx_off_q   <= '0;
      gx_col_q   <= '0;
      gy_in_q    <= GY_IN0;
      gy_off_q   <= '0;
      gy_fila_q  <= '0;
      hs_q       <= ~H_POL;
      vs_q       <= ~V_POL;
      blank_q    <= (H_ACTIVE > 0) && (V_ACTIVE > 0);
      ini_lin_q  <= 1'b0;
      ini_cua_q  <= 1'b0;
      en_celda_q <= GX_IN0 && GY_IN0;
      en_borde_q <= BORDE0;
      col_q      <= '0;
      fila_q     <= '0;
    end else begin
      div_q      <= div_d;
      x_q        <= x_d;
      y_q        <= y_d;
      gx_in_q    <= gx_in_d;
      gx_off_q   <= gx_off_d;
      gx_col_q   <= gx_col_d;
      gy_in_q    <= gy_in_d;
      gy_off_q   <= gy_off_d;
      gy_fila_q  <= gy_fila_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      blank_q    <= blank_d;
      ini_lin_q  <= ini_lin_d;
      ini_cua_q  <= ini_cua_d;
      en_celda_q <= en_celda_d;
      en_borde_q <= en_borde_d;
      col_q      <= col_d;
      fila_q     <= fila_d;
    end
  end

  assign H_SYNC       = hs_q;
  assign V_SYNC       = vs_q;
  assign SYNC_BLANK   = blank_q;
  assign SYNC_B       = 1'b0;
  assign cuentaX      = x_q;
  assign cuentaY      = y_q;
  assign inicioLinea  = ini_lin_q;
  assign inicioCuadro = ini_cua_q;
  assign celdaCol     = col_q;
  assign celdaFila    = fila_q;
  assign enCelda      = en_celda_q;
  assign enBorde      = en_borde_q;

endmodule
`default_nettype wire

// File: tb/tb_controlador_vga_param.sv
`default_nettype none
// tb_controlador_vga_param: directed checks of VGA timing, strobe, pause, reset and grid decode.
module tb_controlador_vga_param;

  logic clk;
  logic rst0_n, en0, rstb_n, enb;

  // default geometry, CLK_DIV=2
  logic a_pix, a_hs, a_vs, a_blk, a_sb, a_il, a_ic, a_ec, a_eb;
  logic [9:0] a_x, a_y;
  logic [1:0] a_col, a_fila;
  // default geometry, CLK_DIV=3
  logic c_pix, c_hs, c_vs, c_blk, c_sb, c_il, c_ic, c_ec, c_eb;
  logic [9:0] c_x, c_y;
  logic [1:0] c_col, c_fila;
  // small timings, positive sync, CLK_DIV=1
  logic s_pix, s_hs, s_vs, s_blk, s_sb, s_il, s_ic, s_ec, s_eb;
  logic [9:0] s_x, s_y;
  logic [0:0] s_col, s_fila;
  // scaled grid, CLK_DIV=1
  logic g_pix, g_hs, g_vs, g_blk, g_sb, g_il, g_ic, g_ec, g_eb;
  logic [9:0] g_x, g_y;
  logic [1:0] g_col, g_fila;

  int n_vec  = 0;
  int n_miss = 0;

  controlador_vga_param #(.CLK_DIV(2)) dut_a (
    .clk(clk), .botonRST(rst0_n), .en(en0), .pix_en(a_pix), .H_SYNC(a_hs), .V_SYNC(a_vs),
    .SYNC_BLANK(a_blk), .SYNC_B(a_sb), .cuentaX(a_x), .cuentaY(a_y), .inicioLinea(a_il),
    .inicioCuadro(a_ic), .celdaCol(a_col), .celdaFila(a_fila), .enCelda(a_ec), .enBorde(a_eb));

  controlador_vga_param #(.CLK_DIV(3)) dut_c (
    .clk(clk), .botonRST(rstb_n), .en(enb), .pix_en(c_pix), .H_SYNC(c_hs), .V_SYNC(c_vs),
    .SYNC_BLANK(c_blk), .SYNC_B(c_sb), .cuentaX(c_x), .cuentaY(c_y), .inicioLinea(c_il),
    .inicioCuadro(c_ic), .celdaCol(c_col), .celdaFila(c_fila), .enCelda(c_ec), .enBorde(c_eb));

  controlador_vga_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SW(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SW(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .GRID_N(2), .CELDA(2), .LINEA(1),
    .ORIG_X(2), .ORIG_Y(0)) dut_s (
    .clk(clk), .botonRST(rstb_n), .en(enb), .pix_en(s_pix), .H_SYNC(s_hs), .V_SYNC(s_vs),
    .SYNC_BLANK(s_blk), .SYNC_B(s_sb), .cuentaX(s_x), .cuentaY(s_y), .inicioLinea(s_il),
    .inicioCuadro(s_ic), .celdaCol(s_col), .celdaFila(s_fila), .enCelda(s_ec), .enBorde(s_eb));

  controlador_vga_param #(
    .H_ACTIVE(64), .H_FP(4), .H_SW(8), .H_BP(4), .V_ACTIVE(48), .V_FP(2), .V_SW(2), .V_BP(2),
    .CLK_DIV(1), .GRID_N(3), .CELDA(16), .LINEA(2), .ORIG_X(8), .ORIG_Y(0)) dut_g (
    .clk(clk), .botonRST(rstb_n), .en(enb), .pix_en(g_pix), .H_SYNC(g_hs), .V_SYNC(g_vs),
    .SYNC_BLANK(g_blk), .SYNC_B(g_sb), .cuentaX(g_x), .cuentaY(g_y), .inicioLinea(g_il),
    .inicioCuadro(g_ic), .celdaCol(g_col), .celdaFila(g_fila), .enCelda(g_ec), .enBorde(g_eb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_a(input int x, input int y);
    int n = 0;
    while (!(int'(a_x) == x && int'(a_y) == y) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40000) chk("wait_a_timeout", x, -1);
  endtask

  task automatic wait_g(input int x, input int y);
    int n = 0;
    while (!(int'(g_x) == x && int'(g_y) == y) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10000) chk("wait_g_timeout", x, -1);
  endtask

  task automatic grid_g(input string tag, input int ec, input int col, input int fila, input int eb);
    chk({tag, "_enCelda"}, int'(g_ec), ec);
    chk({tag, "_col"}, int'(g_col), col);
    chk({tag, "_fila"}, int'(g_fila), fila);
    chk({tag, "_enBorde"}, int'(g_eb), eb);
  endtask

  task automatic grid_a(input string tag, input int ec, input int col, input int fila, input int eb);
    chk({tag, "_enCelda"}, int'(a_ec), ec);
    chk({tag, "_col"}, int'(a_col), col);
    chk({tag, "_fila"}, int'(a_fila), fila);
    chk({tag, "_enBorde"}, int'(a_eb), eb);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cnt;
    rst0_n = 1'b1; rstb_n = 1'b1; en0 = 1'b0; enb = 1'b0;
    #1;
    rst0_n = 1'b0; rstb_n = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_x", int'(a_x), 0);
    chk("rst_y", int'(a_y), 0);
    chk("rst_hsync", int'(a_hs), 1);
    chk("rst_vsync", int'(a_vs), 1);
    chk("rst_blank", int'(a_blk), 1);
    chk("rst_pix_en", int'(a_pix), 0);
    chk("rst_il", int'(a_il), 0);
    chk("rst_ic", int'(a_ic), 0);
    chk("sync_b", int'(a_sb), 0);
    grid_a("rst_grid", 0, 0, 0, 0);
    chk("rst_s_hsync", int'(s_hs), 0);
    chk("rst_s_vsync", int'(s_vs), 0);
    chk("rst_g_pix_en", int'(g_pix), 0);

    rst0_n = 1'b1; rstb_n = 1'b1; en0 = 1'b1; enb = 1'b1;

    // strobe patterns for CLK_DIV = 2, 3, 1
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("div2_pix_en", int'(a_pix), (i % 2 == 0) ? 1 : 0);
      chk("div2_x", int'(a_x), (i + 1) / 2);
      chk("div3_pix_en", int'(c_pix), (i % 3 == 1) ? 1 : 0);
      chk("div3_x", int'(c_x), (i + 1) / 3);
      chk("div1_pix_en", int'(g_pix), 1);
      chk("div1_x", int'(g_x), i + 1);
    end

    wait_a(80, 0);
    grid_a("g80_0", 1, 0, 0, 1);

    // one full line: period and horizontal sync/blank windows
    cnt = 0;
    while (!a_il && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    chk("first_wrap_x", int'(a_x), 0);
    chk("first_wrap_y", int'(a_y), 1);
    chk("first_wrap_ic", int'(a_ic), 0);
    cnt = 0;
    do begin
      chk("hsync_x", int'(a_hs), (int'(a_x) >= 656 && int'(a_x) < 752) ? 0 : 1);
      chk("blank_x", int'(a_blk), (int'(a_x) < 640) ? 1 : 0);
      @(negedge clk);
      cnt++;
    end while (!a_il && cnt < 4000);
    chk("line_period", cnt, 1600);

    wait_a(79, 10);
    grid_a("g79_10", 0, 0, 0, 0);
    wait_a(240, 10);
    grid_a("g240_10", 1, 1, 0, 1);
    wait_a(250, 10);
    grid_a("g250_10", 1, 1, 0, 0);
    wait_a(560, 10);
    grid_a("g560_10", 0, 0, 0, 0);

    // pause for 50 clk at x=300
    wait_a(300, 11);
    en0 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("pause_x", int'(a_x), 300);
      chk("pause_pix_en", int'(a_pix), 0);
      chk("pause_il", int'(a_il), 0);
    end
    en0 = 1'b1;
    @(negedge clk);
    chk("resume_pix_en", int'(a_pix), 1);
    chk("resume_x_hold", int'(a_x), 300);
    @(negedge clk);
    chk("resume_x_next", int'(a_x), 301);

    // asynchronous reset between edges while in sync pulse
    wait_a(700, 11);
    chk("pre_rst_hsync", int'(a_hs), 0);
    #2;
    rst0_n = 1'b0;
    #1;
    chk("arst_x", int'(a_x), 0);
    chk("arst_y", int'(a_y), 0);
    chk("arst_hsync", int'(a_hs), 1);
    chk("arst_vsync", int'(a_vs), 1);
    chk("arst_blank", int'(a_blk), 1);
    chk("arst_pix_en", int'(a_pix), 0);
    grid_a("arst_grid", 0, 0, 0, 0);
    @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    chk("rel_x0", int'(a_x), 0);
    chk("rel_pix_en", int'(a_pix), 1);
    chk("rel_il0", int'(a_il), 0);
    @(negedge clk);
    chk("rel_x1", int'(a_x), 1);
    chk("rel_il1", int'(a_il), 0);
    chk("rel_ic1", int'(a_ic), 0);

    // small timings: one full 14x7 frame
    cnt = 0;
    while (!s_ic && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("s_frame_start_ok", (cnt < 200) ? 1 : 0, 1);
    for (int i = 0; i < 98; i++) begin
      chk("s_x", int'(s_x), i % 14);
      chk("s_y", int'(s_y), i / 14);
      chk("s_hsync", int'(s_hs), (i % 14 == 10 || i % 14 == 11) ? 1 : 0);
      chk("s_vsync", int'(s_vs), (i / 14 == 5) ? 1 : 0);
      chk("s_il", int'(s_il), (i % 14 == 0) ? 1 : 0);
      chk("s_ic", int'(s_ic), (i == 0) ? 1 : 0);
      @(negedge clk);
    end
    chk("s_frame_period", int'(s_ic), 1);
    chk("s_wrap_x", int'(s_x), 0);
    chk("s_wrap_y", int'(s_y), 0);

    // scaled grid decode points
    wait_g(8, 0);
    grid_g("sg8_0", 1, 0, 0, 1);
    wait_g(7, 1);
    grid_g("sg7_1", 0, 0, 0, 0);
    wait_g(56, 10);
    grid_g("sg56_10", 0, 0, 0, 0);
    wait_g(24, 20);
    grid_g("sg24_20", 1, 1, 1, 1);
    wait_g(28, 20);
    grid_g("sg28_20", 1, 1, 1, 0);
    wait_g(55, 47);
    grid_g("sg55_47", 1, 2, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controlador_vga_param.md
Name: controlador_vga_param

Overview:
Parametrised VGA timing generator with built-in pixel clock-enable and a board-grid decoder. It replaces the separate clock divider and fixed 640x480 controller in the game's video path. It runs on the system clock and produces a pixel strobe, sync/blank, pixel coordinates, line/frame pulses, and the board cell under the beam for an NxN board. The video generator consumes these outputs directly.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SW, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SW, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, asserted level of H_SYNC (0 = active-low)
V_POL, 0, asserted level of V_SYNC
CLK_DIV, 2, clk cycles per pixel (>=1)
CNT_W, 10, coordinate width
GRID_N, 3, board is GRID_N x GRID_N cells
CELDA, 160, cell side in pixels
LINEA, 4, border thickness in pixels
ORIG_X, 80, grid left edge
ORIG_Y, 0, grid top edge

Ports:
clk  in  1  system clock
botonRST  in  1  asynchronous active-low reset
en  in  1  run enable; 0 freezes the generator
pix_en  out  1  one-clk pixel strobe
H_SYNC  out  1  horizontal sync
V_SYNC  out  1  vertical sync
SYNC_BLANK  out  1  1 = active video
SYNC_B  out  1  composite sync; constant 0
cuentaX  out  CNT_W  current pixel column
cuentaY  out  CNT_W  current line
inicioLinea  out  1  1-clk pulse when cuentaX becomes 0
inicioCuadro  out  1  1-clk pulse when (cuentaX,cuentaY) becomes (0,0)
celdaCol  out  max(1,clog2(GRID_N))  cell column under beam
celdaFila  out  max(1,clog2(GRID_N))  cell row under beam
enCelda  out  1  beam inside grid
enBorde  out  1  beam on a grid line

Behaviour:
- H_TOTAL = sum of H params; V_TOTAL = sum of V params. Elaboration error if H_TOTAL or V_TOTAL > 2^CNT_W, CLK_DIV < 1, ORIG_X + GRID_N*CELDA > H_ACTIVE, ORIG_Y + GRID_N*CELDA > V_ACTIVE, or LINEA >= CELDA.
- Divider: div counts 0..CLK_DIV-1 while en=1. pix_en=1 for exactly the clk where div=CLK_DIV-1, so one clk in CLK_DIV. If CLK_DIV=1, pix_en=1 on every clk with en=1.
- Counters advance on clk edges with pix_en=1:
  - cuentaX wraps from H_TOTAL-1 to 0, and cuentaY increments on that wrap.
  - cuentaY wraps from V_TOTAL-1 to 0.
- All outputs are registered and update on the same edge as the counters, so every output always describes the presented (cuentaX, cuentaY).
- Sync and blank decode:
  - H_SYNC = H_POL when H_ACTIVE+H_FP <= cuentaX < H_ACTIVE+H_FP+H_SW; otherwise ~H_POL.
  - V_SYNC = V_POL when V_ACTIVE+V_FP <= cuentaY < V_ACTIVE+V_FP+V_SW; otherwise ~V_POL.
  - SYNC_BLANK = (cuentaX < H_ACTIVE) && (cuentaY < V_ACTIVE).
- Line/frame pulses: inicioLinea and inicioCuadro are high for exactly the single clk following the edge that produced the wrap.
- Grid decode (no divider):
  - enCelda = 1 when ORIG_X <= cuentaX < ORIG_X+GRID_N*CELDA and ORIG_Y <= cuentaY < ORIG_Y+GRID_N*CELDA.
  - celdaCol = (cuentaX-ORIG_X)/CELDA and celdaFila = (cuentaY-ORIG_Y)/CELDA. Implement with incremental sub-cell counters.
  - enBorde = enCelda and (offset within cell in X or Y < LINEA, or within the last LINEA pixels of the grid in X or Y).
  - Outside the grid, celdaCol, celdaFila, enCelda and enBorde are all 0.
- en=0: div, counters and all outputs hold; pix_en=0, inicio pulses 0. Resume continues from the held div value.
- Reset (async assert, outputs change immediately without a clk edge):
  - div=0, pix_en=0, cuentaX=cuentaY=0.
  - H_SYNC=~H_POL, V_SYNC=~V_POL, SYNC_BLANK=1.
  - Pulses 0; grid outputs equal the decode of (0,0).
  - After release, the first pix_en occurs on the CLK_DIV-th clk with en=1, and cuentaX then becomes 1.
- Reset asserted mid-frame: same as above; no partial pulses.

Test Plan:
1. Defaults, reset, run 2 frames -> line = 1600 clk, H_SYNC low exactly for cuentaX 656..751, V_SYNC low for cuentaY 490..491, SYNC_BLANK high only for x<640 and y<480, inicioCuadro period 840000 clk.
2. Strobe checks:
   - CLK_DIV=2 -> pix_en toggles 0,1,0,1.
   - CLK_DIV=1 -> pix_en constantly 1 and cuentaX increments every clk.
   - CLK_DIV=3 -> pix_en pattern 0,0,1.
3. Grid at defaults:
   - (79,10) -> enCelda=0.
   - (80,0) -> enCelda=1, col=0, fila=0, enBorde=1.
   - (250,170) -> col=1, fila=1, enBorde=0.
   - (240,200) -> enBorde=1 (X offset 0 of col 1).
   - (557,477) -> col=2, fila=2, enBorde=1.
   - (560,100) -> enCelda=0 and all grid outputs 0.
4. Pause: drop en at cuentaX=300 for 50 clk -> cuentaX stays 300, pix_en=0, no pulses; on raise, counting resumes at 301 with no lost or extra pixel.
5. Async reset: assert botonRST=0 between clk edges at (500,300) -> outputs go to reset values without a clk edge; on release with CLK_DIV=2, cuentaX=1 two clk later, no inicio pulse.
6. Small timings: H 8/2/2/2, V 4/1/1/1, H_POL=V_POL=1, CLK_DIV=1 -> H_SYNC high at x=10..11, V_SYNC high at y=5, X wraps 13->0, Y wraps 6->0, inicioCuadro every 98 clk.
